// File: rtl/stage2_seq.sv
// stage2_seq: sequential stage-2 game engine.
// Starts a round after stage 1 and accepts up to MAX_TRY rolls. It counts
// hits (roll >= THRESH) and lucky rolls (roll == latched luck2, saturating
// at 3), then commits pass2/bonus2 for stage 3. The committed values are
// held until the next commit or until reset.
//
// Ports:
//   clk      in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   start    in   one-cycle round start pulse (honoured only in IDLE)
//   pass1    in   stage-1 result, sampled with start
//   luck2    in   [2:0] lucky number, latched with start
//   roll_vld in   roll strobe (honoured only in PLAY)
//   roll     in   [2:0] roll value
//   pass2    out  committed round result
//   bonus2   out  [1:0] committed lucky count
//   busy     out  high while a round is in progress
//   done     out  one-cycle pulse in the cycle after a commit
module stage2_seq #(
  parameter int MAX_TRY  = 5,
  parameter int NEED_HIT = 3,
  parameter int THRESH   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       pass1,
  input  logic [2:0] luck2,
  input  logic       roll_vld,
  input  logic [2:0] roll,
  output logic       pass2,
  output logic [1:0] bonus2,
  output logic       busy,
  output logic       done
);

  localparam logic [2:0] MAX_L    = 3'(MAX_TRY);
  localparam logic [2:0] NEED_L   = 3'(NEED_HIT);
  // Bit r is set when roll value r counts as a hit; avoids a constant
  // comparison when THRESH is 0.
  localparam logic [7:0] HIT_MASK = 8'hFF << THRESH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t     state_q,     state_d;
  logic [2:0] try_cnt_q,   try_cnt_d;
  logic [2:0] hit_cnt_q,   hit_cnt_d;
  logic [1:0] lucky_cnt_q, lucky_cnt_d;
  logic [2:0] luck_q,      luck_d;
  logic       pass2_q,     pass2_d;
  logic [1:0] bonus2_q,    bonus2_d;

  logic       hit;
  logic       lucky;
  logic [2:0] try_new;
  logic [2:0] hit_new;
  logic [1:0] lucky_new;

  function automatic logic [1:0] sat_inc2(input logic [1:0] v);
    return (v == 2'd3) ? v : v + 2'd1;
  endfunction

  always_comb begin
    state_d     = state_q;
    try_cnt_d   = try_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    lucky_cnt_d = lucky_cnt_q;
    luck_d      = luck_q;
    pass2_d     = pass2_q;
    bonus2_d    = bonus2_q;

    hit       = HIT_MASK[roll];
    lucky     = (roll == luck_q);
    try_new   = try_cnt_q + 3'd1;
    hit_new   = hit_cnt_q + {2'b00, hit};
    lucky_new = lucky ? sat_inc2(lucky_cnt_q) : lucky_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (pass1) begin
            state_d     = PLAY;
            luck_d      = luck2;
            try_cnt_d   = 3'd0;
            hit_cnt_d   = 3'd0;
            lucky_cnt_d = 2'd0;
          end else begin
            // Stage 1 already lost: commit a failed result immediately.
            state_d  = FIN;
            pass2_d  = 1'b0;
            bonus2_d = 2'd0;
          end
        end
      end
      PLAY: begin
        if (roll_vld) begin
          try_cnt_d   = try_new;
          hit_cnt_d   = hit_new;
          lucky_cnt_d = lucky_new;
          // Decide on the updated counts; a pass wins over running out of tries.
          if (hit_new == NEED_L) begin
            state_d  = FIN;
            pass2_d  = 1'b1;
            bonus2_d = lucky_new;
          end else if (try_new == MAX_L) begin
            state_d  = FIN;
            pass2_d  = 1'b0;
            bonus2_d = 2'd0;
          end
        end
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      try_cnt_q   <= 3'd0;
      hit_cnt_q   <= 3'd0;
      lucky_cnt_q <= 2'd0;
      luck_q      <= 3'd0;
      pass2_q     <= 1'b0;
      bonus2_q    <= 2'd0;
    end else begin
      state_q     <= state_d;
      try_cnt_q   <= try_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      lucky_cnt_q <= lucky_cnt_d;
      luck_q      <= luck_d;
      pass2_q     <= pass2_d;
      bonus2_q    <= bonus2_d;
    end
  end

  assign pass2  = pass2_q;
  assign bonus2 = bonus2_q;
  assign busy   = (state_q == PLAY);
  assign done   = (state_q == FIN);

endmodule

// File: doc/stage2_seq.md
Name: stage2_seq

Overview:
- Sequential stage-2 game engine. It runs a multi-roll round after stage 1 and produces the pass2 and bonus2 values that stage 3 consumes alongside slide, timing and luck3.
- Outputs are registered and held stable between rounds, so stage 3 can sample them combinationally at any time.

Parameters:
- MAX_TRY, 5, maximum rolls accepted per round (1..7).
- NEED_HIT, 3, hits required to pass (1..MAX_TRY).
- THRESH, 4, minimum roll value (0..7) counted as a hit.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a round.
- pass1  input  1  stage-1 result; sampled with start.
- luck2  input  3  lucky number; latched with start.
- roll_vld  input  1  roll strobe.
- roll  input  3  roll value; sampled when roll_vld=1.
- pass2  output  1  round result to stage 3.
- bonus2  output  2  bonus count to stage 3.
- busy  output  1  high while in PLAY.
- done  output  1  one-cycle pulse when a result is committed.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pass2=0, bonus2=0, busy=0, done=0.
  - try_cnt=0, hit_cnt=0, lucky_cnt=0, luck_q=0.
- States: IDLE, PLAY, FIN. busy=1 only in PLAY.
- IDLE, start=1 and pass1=0:
  - go to FIN.
  - commit pass2=0, bonus2=0 at that edge.
- IDLE, start=1 and pass1=1:
  - go to PLAY.
  - luck_q<=luck2; clear try_cnt, hit_cnt, lucky_cnt.
  - pass2/bonus2 keep their previous values until commit.
- roll_vld in IDLE or FIN is ignored, including in the start cycle.
- PLAY, roll_vld=1 (accepted roll):
  - try_cnt+1.
  - hit = (roll >= THRESH); hit_cnt + hit.
  - lucky = (roll == luck_q); lucky_cnt + lucky, saturating at 3 (2-bit).
  - A roll can be both a hit and lucky.
- Termination is evaluated on the updated counts in the same edge as the accepting roll:
  - new hit_cnt == NEED_HIT → commit pass2=1, bonus2=new lucky_cnt; go to FIN.
  - else if new try_cnt == MAX_TRY → commit pass2=0, bonus2=0; go to FIN.
  - else stay in PLAY.
  - Pass takes priority when both conditions hit on the same roll.
- PLAY, roll_vld=0: hold all state.
- start while in PLAY or FIN is ignored; no restart mid-round.
- FIN:
  - done=1 for exactly this one cycle, then unconditional return to IDLE.
  - Latency: commit edge → done high in the following cycle.
  - pass2/bonus2 are already valid in the done cycle.
- pass2 and bonus2 change only at a commit edge or on reset, and hold indefinitely otherwise.
- Reset mid-round: immediate return to IDLE with all outputs 0; the partial round is discarded and done is not asserted.
- Counters are 3 bits; try_cnt never exceeds MAX_TRY.

Test Plan:
- Reset then idle: rst_n low 2 cycles, release, no stimulus → pass2=0, bonus2=0, busy=0, done=0 for 10 cycles.
- Stage-1 fail: start=1, pass1=0 → next cycle done=1, pass2=0, bonus2=0; busy never asserted; roll_vld pulses during the round have no effect.
- Clean pass (defaults), luck2=6, start, then rolls:
  - rolls 5,6,2,7 with roll_vld gaps of 0–3 cycles.
  - pass2=1 after the 4th roll (hits 5,6,7 → 3); bonus2=1 (one 6); done pulses once.
  - busy falls the cycle after the 4th roll is accepted.
- Fail on tries, luck2=1, rolls 1,1,1,4,0:
  - only 1 hit, 5 tries → pass2=0, bonus2=0 (lucky count of 3 discarded); done=1.
- Bonus saturation, NEED_HIT=5, MAX_TRY=7, THRESH=0, luck2=3, rolls 3,3,3,3,3 → pass2=1, bonus2=3 (not wrapping to 0).
- Robustness:
  - start asserted during PLAY → ignored, luck_q unchanged.
  - rst_n pulsed low after 2 rolls → outputs 0, state IDLE, no done.
  - new start afterwards completes a full round normally.
